// File: rtl/iq_pkg.sv
// Shared sizing and age-matrix type for the issue-queue age scheduler.
package iq_pkg;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned IQ_IDX_W = $clog2(IQ_DEPTH);

  // older[i][j] = 1 means entry i was dispatched before entry j
  typedef logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] age_matrix_t;

endpackage

// File: rtl/age_oldest_sel.sv
// Combinational oldest-eligible selection over an age matrix.
module age_oldest_sel
  import iq_pkg::*;
(
  input  logic [IQ_DEPTH-1:0] eligible,
  input  age_matrix_t         matrix,
  output logic                valid,
  output logic [IQ_IDX_W-1:0] idx,
  output logic [IQ_DEPTH-1:0] onehot
);

  logic blocked;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    blocked = 1'b0;
    // an eligible entry wins when no other eligible entry is older than it
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < IQ_DEPTH; j++) begin
        blocked = blocked | (eligible[j] & matrix[j][i]);
      end
      onehot[i] = eligible[i] & ~blocked;
    end
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      if (onehot[i]) idx = idx | i[IQ_IDX_W-1:0];
    end
    valid = |onehot;
  end

endmodule

// File: rtl/iq_age_scheduler.sv
// Oldest-ready-first issue scheduler built on an age matrix.
// Optional perf counters: define IQ_AGE_PERF_EN.
module iq_age_scheduler
  import iq_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = iq_pkg::IQ_DEPTH,
  parameter int unsigned IQ_IDX_W = $clog2(IQ_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [IQ_IDX_W-1:0] alloc_idx,
  input  logic [IQ_DEPTH-1:0] req_vec,
  input  logic                issue_accept,
  input  logic [IQ_DEPTH-1:0] flush_vec,
  output logic                grant_valid,
  output logic [IQ_IDX_W-1:0] grant_idx,
  output logic [IQ_DEPTH-1:0] grant_onehot,
  output logic [IQ_DEPTH-1:0] occupied,
  output logic                alloc_err
`ifdef IQ_AGE_PERF_EN
  ,
  output logic [31:0]         perf_issue_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  age_matrix_t         older_q, older_d;
  logic [IQ_DEPTH-1:0] occ_q, occ_d, eligible, freed, keep;
  logic                do_alloc, err_d;

  assign eligible = req_vec & occ_q & ~flush_vec;
  assign occupied = occ_q;

  age_oldest_sel u_sel (
    .eligible (eligible),
    .matrix   (older_q),
    .valid    (grant_valid),
    .idx      (grant_idx),
    .onehot   (grant_onehot)
  );

  always_comb begin
    freed    = (flush_vec & occ_q) | ((grant_valid && issue_accept) ? grant_onehot : '0);
    keep     = occ_q & ~freed;
    do_alloc = alloc_valid && !occ_q[alloc_idx];
    err_d    = alloc_err | (alloc_valid && occ_q[alloc_idx]);
    occ_d    = keep;
    older_d  = '0;
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      for (int unsigned j = 0; j < IQ_DEPTH; j++) begin
        older_d[i][j] = older_q[i][j] & keep[i] & keep[j];
      end
    end
    // row of a free slot is already zero; new entry is younger than all survivors
    if (do_alloc) begin
      occ_d[alloc_idx] = 1'b1;
      for (int unsigned j = 0; j < IQ_DEPTH; j++) begin
        older_d[j][alloc_idx] = keep[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q     <= '0;
      older_q   <= '0;
      alloc_err <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      older_q   <= older_d;
      alloc_err <= err_d;
    end
  end

`ifdef IQ_AGE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant_valid && issue_accept && perf_issue_cnt != '1)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (occ_q != '0 && !grant_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iq_age_scheduler.sv
// Self-checking bench: dispatch-order queue model plus directed scenarios and random traffic.
module tb_iq_age_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_valid = 1'b0;
  logic [1:0] alloc_idx = '0;
  logic [3:0] req_vec = '0;
  logic       issue_accept = 1'b0;
  logic [3:0] flush_vec = '0;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] grant_onehot;
  logic [3:0] occupied;
  logic       alloc_err;
`ifdef IQ_AGE_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // model: entries in dispatch order, oldest at the front
  int          q[$];
  bit          m_err;
  int unsigned m_issue, m_stall;

  always #5 clk = ~clk;

  iq_age_scheduler #(.IQ_DEPTH(4), .IQ_IDX_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_idx    (alloc_idx),
    .req_vec      (req_vec),
    .issue_accept (issue_accept),
    .flush_vec    (flush_vec),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .occupied     (occupied),
    .alloc_err    (alloc_err)
`ifdef IQ_AGE_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_occ();
    logic [3:0] v = '0;
    foreach (q[k]) v[q[k]] = 1'b1;
    return v;
  endfunction

  function automatic int m_grant();
    foreach (q[k]) if (req_vec[q[k]] && !flush_vec[q[k]]) return q[k];
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 0);
    chk({tag, "_grant_idx"}, 32'(grant_idx), 0);
    chk({tag, "_grant_onehot"}, 32'(grant_onehot), 0);
    chk({tag, "_occupied"}, 32'(occupied), 0);
    chk({tag, "_alloc_err"}, 32'(alloc_err), 0);
  endtask

  // drive inputs at the negedge, then compare settled outputs to the model
  task automatic step(input bit av, input int ai, input logic [3:0] rq, input bit acc,
                      input logic [3:0] fl);
    int g;
    logic [1:0] ai2;
    ai2 = ai[1:0];
    alloc_valid = av; alloc_idx = ai2; req_vec = rq; issue_accept = acc; flush_vec = fl;
    #2;
    g = m_grant();
    chk("grant_valid", 32'(grant_valid), (g >= 0) ? 1 : 0);
    chk("grant_idx", 32'(grant_idx), (g >= 0) ? g : 0);
    chk("grant_onehot", 32'(grant_onehot), (g >= 0) ? (1 << g) : 0);
    chk("occupied", 32'(occupied), 32'(m_occ()));
    chk("alloc_err", 32'(alloc_err), 32'(m_err));
`ifdef IQ_AGE_PERF_EN
    chk("perf_issue_cnt", perf_issue_cnt, m_issue);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
  endtask

  task automatic tick();
    int g;
    logic [3:0] occ0;
    int nq[$];
    g = m_grant();
    occ0 = m_occ();
    if (g >= 0 && issue_accept && m_issue != 32'hFFFF_FFFF) m_issue++;
    if (occ0 != 0 && g < 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(posedge clk);
    foreach (q[k]) begin
      if (!(flush_vec[q[k]] || (issue_accept && q[k] == g))) nq.push_back(q[k]);
    end
    if (alloc_valid) begin
      if (occ0[alloc_idx]) m_err = 1'b1;
      else nq.push_back(int'(alloc_idx));
    end
    q = nq;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 1'b0;
    m_issue = 0;
    m_stall = 0;
  endtask

  initial begin
    model_reset();
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // alloc 2,0,3 then oldest-ready order 2,0,3
    step(1, 2, 4'b0000, 0, 4'b0000); tick();
    step(1, 0, 4'b0000, 0, 4'b0000); tick();
    step(1, 3, 4'b0000, 0, 4'b0000); tick();
    step(0, 0, 4'b1101, 1, 4'b0000); chk("seq_first", 32'(grant_idx), 2); tick();
    step(0, 0, 4'b1101, 1, 4'b0000); chk("seq_second", 32'(grant_idx), 0); tick();
    step(0, 0, 4'b1101, 1, 4'b0000); chk("seq_third", 32'(grant_idx), 3); tick();
    step(0, 0, 4'b0000, 0, 4'b0000); chk("seq_empty", 32'(occupied), 0); tick();

    // older entry 1 not ready, younger 3 granted; then 1 wins
    step(1, 1, 4'b0000, 0, 4'b0000); tick();
    step(1, 3, 4'b0000, 0, 4'b0000); tick();
    step(0, 0, 4'b1000, 0, 4'b0000); chk("young_only", 32'(grant_idx), 3); tick();
    step(0, 0, 4'b1010, 1, 4'b0000); chk("old_wins", 32'(grant_idx), 1); tick();
    step(0, 0, 4'b0000, 0, 4'b1000); tick();

    // flush with same-cycle alloc
    step(1, 0, 4'b0000, 0, 4'b0000); tick();
    step(1, 1, 4'b0000, 0, 4'b0000); tick();
    step(1, 2, 4'b0000, 0, 4'b0000); tick();
    step(1, 3, 4'b0000, 0, 4'b0110); tick();
    step(0, 0, 4'b1001, 0, 4'b0000);
    chk("flush_occ", 32'(occupied), 32'b1001);
    chk("flush_age", 32'(grant_idx), 0);
    tick();
    step(0, 0, 4'b0000, 0, 4'b1001); tick();

    // held grant without accept
    step(1, 0, 4'b0000, 0, 4'b0000); tick();
    step(1, 1, 4'b0000, 0, 4'b0000); tick();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b0010, 0, 4'b0000);
      chk("hold_idx", 32'(grant_idx), 1);
      chk("hold_occ", 32'(occupied), 32'b0011);
      tick();
    end
    step(0, 0, 4'b0010, 1, 4'b0000); tick();
    step(0, 0, 4'b0000, 0, 4'b0000); chk("accept_frees", 32'(occupied), 32'b0001); tick();

    // alloc into occupied entry is an error and leaves ages alone
    step(1, 2, 4'b0000, 0, 4'b0000); tick();
    step(1, 2, 4'b0000, 0, 4'b0000); tick();
    step(0, 0, 4'b0101, 0, 4'b0000);
    chk("err_sticky", 32'(alloc_err), 1);
    chk("err_occ", 32'(occupied), 32'b0101);
    chk("err_age", 32'(grant_idx), 0);
    tick();

    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 4'($urandom),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);
      tick();
    end

    // asynchronous reset mid-run
    step(1, int'($urandom_range(0, 3)), 4'b1111, 0, 4'b0000);
    #3 rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    alloc_valid = 1'b0; req_vec = '0; issue_accept = 1'b0; flush_vec = '0;
    @(negedge clk);
    rst = 1'b1;

    // stall and issue accounting
    step(1, 0, 4'b0000, 0, 4'b0000); tick();
    step(1, 1, 4'b0000, 0, 4'b0000); tick();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'b0000, 0, 4'b0000); tick();
    end
    step(0, 0, 4'b0011, 1, 4'b0000); tick();
    step(0, 0, 4'b0011, 1, 4'b0000); tick();
    step(0, 0, 4'b0000, 0, 4'b0000);
    chk("perf_drained", 32'(occupied), 0);
`ifdef IQ_AGE_PERF_EN
    chk("perf_stall_lit", perf_stall_cnt, 5);
    chk("perf_issue_lit", perf_issue_cnt, 2);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iq_age_scheduler.md
IQ_AGE_SCHEDULER -- requirements
Module: iq_age_scheduler

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4: number of issue-queue entries scheduled.
REQ-002 SHALL have parameter IQ_IDX_W, default $clog2(IQ_DEPTH): width of an entry index.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port alloc_valid  in  1  a dispatch writes an entry this cycle.
REQ-006 SHALL have port alloc_idx  in  IQ_IDX_W  entry written by the dispatch.
REQ-007 SHALL have port req_vec  in  IQ_DEPTH  per entry: operands ready and target FU ready.
REQ-008 SHALL have port issue_accept  in  1  register-read stage accepts the granted entry.
REQ-009 SHALL have port flush_vec  in  IQ_DEPTH  per entry: killed by mispredict this cycle.
REQ-010 SHALL have port grant_valid  out  1  some entry is selected for issue.
REQ-011 SHALL have port grant_idx  out  IQ_IDX_W  selected entry; 0 when grant_valid=0.
REQ-012 SHALL have port grant_onehot  out  IQ_DEPTH  one-hot of grant_idx; all-zero when grant_valid=0.
REQ-013 SHALL have port occupied  out  IQ_DEPTH  tracked occupancy per entry.
REQ-014 SHALL have port alloc_err  out  1  sticky: dispatch targeted an occupied entry.

Function
REQ-015 SHALL keep an IQ_DEPTH x IQ_DEPTH age matrix; older[i][j]=1 means entry i dispatched before entry j.
REQ-016 SHALL maintain invariant: for occupied i!=j exactly one of older[i][j], older[j][i] is 1; rows/columns of unoccupied entries all 0.
REQ-017 SHALL form eligible = req_vec & occupied & ~flush_vec; req_vec bits of unoccupied entries are ignored.
REQ-018 SHALL grant, combinationally (zero latency), the eligible entry i with no eligible j having older[j][i]=1 (oldest-ready first).
REQ-019 SHALL free entry g at the clock edge when grant_valid && issue_accept; grant with issue_accept=0 changes no state.
REQ-020 SHALL free every entry with flush_vec=1 that is occupied at the start of the cycle; flush of an unoccupied entry has no effect.
REQ-021 SHALL, on free of entry k, clear occupied[k], row k and column k.
REQ-022 SHALL, on alloc_valid with occupied[alloc_idx]=0, set occupied[alloc_idx], clear row alloc_idx, and set older[j][alloc_idx]=1 for every j occupied and not freed this cycle.
REQ-023 SHALL allow alloc and free (issue and/or flush) in the same cycle; the new entry is youngest and is not affected by that cycle's flush_vec.
REQ-024 SHALL, on alloc_valid with occupied[alloc_idx]=1, ignore the allocation and set alloc_err, which holds until reset.
REQ-025 SHALL accept alloc into an entry being freed the same cycle only as an error (REQ-024); occupancy is evaluated at cycle start.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear occupied, age matrix, alloc_err and perf counters.
REQ-027 SHALL therefore drive grant_valid=0, grant_idx=0, grant_onehot=0, occupied=0, alloc_err=0 during and immediately after reset; reset mid-operation discards all tracked entries.

Configuration
REQ-028 SHALL, with macro IQ_AGE_PERF_EN defined, add outputs perf_issue_cnt (32) counting cycles with grant_valid&&issue_accept, and perf_stall_cnt (32) counting cycles with occupied!=0 and grant_valid=0, both saturating at 32'hFFFF_FFFF.
REQ-029 SHALL, without IQ_AGE_PERF_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-030 SHALL take IQ_DEPTH, IQ_IDX_W and the age-matrix typedef from the shared package iq_pkg.
REQ-031 SHALL place the combinational oldest-eligible selection in one sub-module, age_oldest_sel (inputs eligible, matrix; outputs valid, idx, onehot).

Verification
REQ-032 SHALL cover: alloc 2,0,3 in consecutive cycles, req_vec=4'b1101 -> grant_idx=2; accept -> next grant_idx=0, then 3.
REQ-033 SHALL cover: entries 1 (older), 3 occupied, req_vec=4'b1000 -> grant_idx=3; req_vec=4'b1010 next cycle -> grant_idx=1.
REQ-034 SHALL cover: occupied=4'b0111, flush_vec=4'b0110 with alloc_idx=3 same cycle -> occupied=4'b1001, entry 3 younger than 0.
REQ-035 SHALL cover: grant_idx=1 with issue_accept=0 for 3 cycles -> occupied unchanged, grant_idx stays 1; accept -> occupied[1]=0.
REQ-036 SHALL cover: alloc_idx=2 while occupied[2]=1 -> alloc_err=1, matrix unchanged; rst low mid-run -> all outputs 0 asynchronously.
REQ-037 SHALL cover (IQ_AGE_PERF_EN): 5 cycles occupied with req_vec=0, then 2 accepted grants -> perf_stall_cnt=5, perf_issue_cnt=2.
